// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Initiator-side front end for a combinational ALU. A command (operands +
// op select) is accepted over a valid/ready handshake, driven onto the ALU
// inputs, held for SETTLE_CYC cycles, and the ALU result is then captured
// and offered over a second valid/ready handshake together with the op that
// produced it and a locally computed divide-by-zero flag.
//
// Parameters
//   DATA_W     ALU operand width
//   RES_W      ALU result width (>= 2*DATA_W)
//   SETTLE_CYC cycles operands sit on the ALU before F is sampled (1..15)
//   CNT_W      width of the completed-operation counter
//
// Ports
//   clk, rst                       clock (rising edge), sync active-high reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_a, cmd_b, cmd_sel          command operands / op (00 add, 01 sub,
//                                  10 mul, 11 div)
//   alu_a, alu_b, alu_sel          registered drive to the ALU
//   alu_f                          ALU result input
//   rsp_valid/rsp_ready            response handshake
//   rsp_data, rsp_sel, rsp_div0    captured result, its op, div-by-zero flag
//   busy                           high whenever not IDLE
//   op_count                       completed response handshakes (wraps)
// ---------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int DATA_W     = 4,
    parameter int RES_W      = 8,
    parameter int SETTLE_CYC = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [1:0]        cmd_sel,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_sel,
    input  logic [RES_W-1:0]  alu_f,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [RES_W-1:0]  rsp_data,
    output logic [1:0]        rsp_sel,
    output logic              rsp_div0,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);

    // Settle counter only has to hold SETTLE_CYC-1, at most 14.
    localparam int              SC_W        = 4;
    localparam logic [SC_W-1:0] SETTLE_LOAD = SC_W'(SETTLE_CYC - 1);
    localparam logic [1:0]      SEL_DIV     = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t          state;
    logic [SC_W-1:0] settle_cnt;
    logic            div0_q;     // div-by-zero, decided from the operands at accept time

    logic cmd_fire;
    logic rsp_fire;

    assign cmd_fire = cmd_valid && cmd_ready;
    assign rsp_fire = rsp_valid && rsp_ready;

    // Single-process FSM; cmd_ready and busy are registered alongside the
    // state so they always reflect the state the sequencer is in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            div0_q     <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_sel    <= '0;
            rsp_div0   <= 1'b0;
            op_count   <= '0;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // alu_* keep their previous values while idle.
                    if (cmd_fire) begin
                        alu_a      <= cmd_a;
                        alu_b      <= cmd_b;
                        alu_sel    <= cmd_sel;
                        div0_q     <= (cmd_sel == SEL_DIV) && (cmd_b == '0);
                        settle_cnt <= SETTLE_LOAD;
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= DRIVE;
                    end
                end

                DRIVE: begin
                    // Operands have been on the ALU for SETTLE_CYC cycles
                    // when the counter reaches zero.
                    if (settle_cnt == '0) begin
                        rsp_data  <= alu_f;
                        rsp_sel   <= alu_sel;
                        rsp_div0  <= div0_q;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        settle_cnt <= settle_cnt - SC_W'(1);
                    end
                end

                RESP: begin
                    // Response fields stay frozen until the consumer takes them.
                    if (rsp_fire) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + CNT_W'(1);
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: one instance with default parameters
// and one with SETTLE_CYC=4 / CNT_W=2, each wired to a behavioural ALU.
module tb_alu_cmd_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural 4-bit ALU ----------------
    function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [1:0] s);
        logic [7:0] ea, eb;
        ea = {4'b0, a};
        eb = {4'b0, b};
        case (s)
            2'b00:   return ea + eb;
            2'b01:   return ea - eb;
            2'b10:   return ea * eb;
            default: return (b == 4'd0) ? 8'h00 : ea / eb;
        endcase
    endfunction

    // ---------------- instance 1: defaults ----------------
    logic       rst1, cmd_valid1, cmd_ready1, rsp_valid1, rsp_ready1, rsp_div01, busy1;
    logic [3:0] cmd_a1, cmd_b1, alu_a1, alu_b1;
    logic [1:0] cmd_sel1, alu_sel1, rsp_sel1;
    logic [7:0] alu_f1, rsp_data1;
    logic [15:0] op_count1;

    always_comb alu_f1 = alu_model(alu_a1, alu_b1, alu_sel1);

    alu_cmd_sequencer dut1 (
        .clk(clk), .rst(rst1),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_a(cmd_a1), .cmd_b(cmd_b1), .cmd_sel(cmd_sel1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_sel(alu_sel1), .alu_f(alu_f1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_data(rsp_data1), .rsp_sel(rsp_sel1), .rsp_div0(rsp_div01),
        .busy(busy1), .op_count(op_count1)
    );

    // ---------------- instance 4: SETTLE_CYC=4, CNT_W=2 ----------------
    logic       rst4, cmd_valid4, cmd_ready4, rsp_valid4, rsp_ready4, rsp_div04, busy4;
    logic [3:0] cmd_a4, cmd_b4, alu_a4, alu_b4;
    logic [1:0] cmd_sel4, alu_sel4, rsp_sel4;
    logic [7:0] alu_f4, rsp_data4;
    logic [1:0] op_count4;

    always_comb alu_f4 = alu_model(alu_a4, alu_b4, alu_sel4);

    alu_cmd_sequencer #(.SETTLE_CYC(4), .CNT_W(2)) dut4 (
        .clk(clk), .rst(rst4),
        .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4),
        .cmd_a(cmd_a4), .cmd_b(cmd_b4), .cmd_sel(cmd_sel4),
        .alu_a(alu_a4), .alu_b(alu_b4), .alu_sel(alu_sel4), .alu_f(alu_f4),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
        .rsp_data(rsp_data4), .rsp_sel(rsp_sel4), .rsp_div0(rsp_div04),
        .busy(busy4), .op_count(op_count4)
    );

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction on instance 1 with rsp_ready high once the result is up.
    task automatic run_op1(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s,
                           input logic [7:0] exp_data, input logic exp_div0,
                           input logic [15:0] exp_cnt);
        cmd_valid1 = 1'b1; cmd_a1 = a; cmd_b1 = b; cmd_sel1 = s;
        tick();                         // handshake edge
        cmd_valid1 = 1'b0;
        chk("op_busy", busy1, 1);
        tick();                         // capture edge
        chk("op_rsp_valid", rsp_valid1, 1);
        chk("op_rsp_data", rsp_data1, exp_data);
        chk("op_rsp_sel", rsp_sel1, s);
        chk("op_rsp_div0", rsp_div01, exp_div0);
        rsp_ready1 = 1'b1;
        tick();                         // response handshake edge
        rsp_ready1 = 1'b0;
        chk("op_done_valid", rsp_valid1, 0);
        chk("op_done_count", op_count1, exp_cnt);
    endtask

    initial begin
        rst1 = 1'b1; cmd_valid1 = 1'b0; cmd_a1 = '0; cmd_b1 = '0; cmd_sel1 = '0; rsp_ready1 = 1'b0;
        rst4 = 1'b1; cmd_valid4 = 1'b0; cmd_a4 = '0; cmd_b4 = '0; cmd_sel4 = '0; rsp_ready4 = 1'b0;
        tick();
        tick();

        // ---- reset state ----
        chk("rst_cmd_ready", cmd_ready1, 1);
        chk("rst_busy", busy1, 0);
        chk("rst_rsp_valid", rsp_valid1, 0);
        chk("rst_op_count", op_count1, 0);
        chk("rst_alu_a", alu_a1, 0);
        chk("rst_rsp_data", rsp_data1, 0);
        rst1 = 1'b0;
        tick();

        // ---- add 9+7, with latency and stepwise state ----
        cmd_valid1 = 1'b1; cmd_a1 = 4'd9; cmd_b1 = 4'd7; cmd_sel1 = 2'b00;
        tick();
        cmd_valid1 = 1'b0;
        chk("add_cmd_ready", cmd_ready1, 0);
        chk("add_busy", busy1, 1);
        chk("add_alu_a", alu_a1, 9);
        chk("add_alu_b", alu_b1, 7);
        chk("add_not_yet_valid", rsp_valid1, 0);
        tick();
        chk("add_rsp_valid", rsp_valid1, 1);
        chk("add_rsp_data", rsp_data1, 8'h10);
        chk("add_rsp_div0", rsp_div01, 0);
        chk("add_count_before", op_count1, 0);
        rsp_ready1 = 1'b1;
        tick();
        rsp_ready1 = 1'b0;
        chk("add_count_after", op_count1, 1);
        chk("add_cmd_ready_back", cmd_ready1, 1);
        chk("add_busy_back", busy1, 0);

        // ---- sub then mul back-to-back, rsp_ready held high ----
        rsp_ready1 = 1'b1;
        cmd_valid1 = 1'b1; cmd_a1 = 4'd3; cmd_b1 = 4'd5; cmd_sel1 = 2'b01;
        tick();                                     // handshake of sub
        chk("b2b_sub_alu_a", alu_a1, 3);
        chk("b2b_sub_ready", cmd_ready1, 0);
        cmd_a1 = 4'd15; cmd_b1 = 4'd15; cmd_sel1 = 2'b10;   // next cmd waits, held
        tick();
        chk("b2b_sub_valid", rsp_valid1, 1);
        chk("b2b_sub_data", rsp_data1, 8'hFE);
        chk("b2b_sub_sel", rsp_sel1, 2'b01);
        chk("b2b_alu_a_held", alu_a1, 3);
        chk("b2b_ready_still_low", cmd_ready1, 0);
        tick();                                     // rsp handshake
        chk("b2b_ready_rises", cmd_ready1, 1);
        chk("b2b_count_2", op_count1, 2);
        tick();                                     // mul handshake, 3 cycles after sub
        cmd_valid1 = 1'b0;
        chk("b2b_mul_alu_a", alu_a1, 15);
        chk("b2b_mul_ready", cmd_ready1, 0);
        tick();
        chk("b2b_mul_valid", rsp_valid1, 1);
        chk("b2b_mul_data", rsp_data1, 8'hE1);
        tick();
        chk("b2b_count_3", op_count1, 3);
        rsp_ready1 = 1'b0;

        // ---- divide ----
        run_op1(4'd13, 4'd4, 2'b11, 8'h03, 1'b0, 16'd4);
        run_op1(4'd13, 4'd0, 2'b11, 8'h00, 1'b1, 16'd5);

        // ---- backpressure ----
        cmd_valid1 = 1'b1; cmd_a1 = 4'd2; cmd_b1 = 4'd3; cmd_sel1 = 2'b10;
        tick();
        cmd_a1 = 4'd1; cmd_b1 = 4'd1; cmd_sel1 = 2'b00;    // ignored while busy
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", rsp_valid1, 1);
            chk("bp_data", rsp_data1, 8'h06);
            chk("bp_sel", rsp_sel1, 2'b10);
            chk("bp_div0", rsp_div01, 0);
            chk("bp_cmd_ready", cmd_ready1, 0);
            chk("bp_busy", busy1, 1);
            chk("bp_count", op_count1, 5);
            chk("bp_alu_a", alu_a1, 2);
            tick();
        end
        cmd_valid1 = 1'b0;
        rsp_ready1 = 1'b1;
        tick();
        rsp_ready1 = 1'b0;
        chk("bp_count_after", op_count1, 6);
        chk("bp_valid_after", rsp_valid1, 0);

        // ---- reset while in DRIVE ----
        cmd_valid1 = 1'b1; cmd_a1 = 4'd5; cmd_b1 = 4'd5; cmd_sel1 = 2'b00;
        tick();
        cmd_valid1 = 1'b0;
        chk("rd_in_drive", busy1, 1);
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        chk("rd_valid", rsp_valid1, 0);
        chk("rd_alu_a", alu_a1, 0);
        chk("rd_count", op_count1, 0);
        chk("rd_cmd_ready", cmd_ready1, 1);

        // ---- reset while in RESP with rsp_ready low ----
        cmd_valid1 = 1'b1; cmd_a1 = 4'd4; cmd_b1 = 4'd4; cmd_sel1 = 2'b00;
        tick();
        cmd_valid1 = 1'b0;
        tick();
        chk("rr_in_resp", rsp_valid1, 1);
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        chk("rr_valid", rsp_valid1, 0);
        chk("rr_alu_b", alu_b1, 0);
        chk("rr_rsp_data", rsp_data1, 0);
        chk("rr_count", op_count1, 0);
        chk("rr_cmd_ready", cmd_ready1, 1);
        run_op1(4'd1, 4'd2, 2'b00, 8'h03, 1'b0, 16'd1);

        // ---- SETTLE_CYC=4 latency and 2-bit counter wrap ----
        rst4 = 1'b0;
        tick();
        chk("s4_rst_count", op_count4, 0);
        for (int i = 0; i < 4; i++) begin
            cmd_valid4 = 1'b1; cmd_a4 = 4'(i + 1); cmd_b4 = 4'd2; cmd_sel4 = 2'b10;
            tick();                                 // handshake edge N
            cmd_valid4 = 1'b0;
            for (int k = 1; k < 4; k++) begin
                tick();
                chk("s4_not_yet_valid", rsp_valid4, 0);
                chk("s4_busy", busy4, 1);
            end
            tick();                                 // edge N+4
            chk("s4_valid", rsp_valid4, 1);
            chk("s4_data", rsp_data4, 2 * (i + 1));
            rsp_ready4 = 1'b1;
            tick();
            rsp_ready4 = 1'b0;
            chk("s4_count", op_count4, (i + 1) % 4);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
